ccff_chain_loader: RTL and testbench



---
 rtl/ccff_chain_loader.sv | 197 +++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Serially loads a configuration-flop chain from host words, then recirculates it once
// while CRC-8 checking the readback stream against the stream that was shifted in.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int WORD_W    = 8
) (
    input  logic                           prog_clk,
    input  logic                           pReset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [WORD_W-1:0]              cfg_data,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    output logic                           ccff_head,
    input  logic                           ccff_tail,
    output logic                           shift_en,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int BC_W      = $clog2(CHAIN_LEN + 1);
    localparam int RC_W      = $clog2(WORD_W + 1);
    localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int WA_W      = $clog2(NUM_WORDS + 1);

    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(CHAIN_LEN);
    localparam logic [BC_W-1:0] BC_ZERO   = {BC_W{1'b0}};
    localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
    localparam logic [RC_W-1:0] RC_ZERO   = {RC_W{1'b0}};
    localparam logic [RC_W-1:0] RC_ONE    = RC_W'(1);
    localparam logic [RC_W-1:0] WORD_CNT  = RC_W'(WORD_W);
    localparam logic [WA_W-1:0] WA_ZERO   = {WA_W{1'b0}};
    localparam logic [WA_W-1:0] WA_ONE    = WA_W'(1);
    localparam logic [WA_W-1:0] WORDS_MAX = WA_W'(NUM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    state_t            r_state,      w_state_nxt;
    logic [WORD_W-1:0] r_buf,        w_buf_nxt;
    logic [RC_W-1:0]   r_cnt,        w_cnt_nxt;
    logic [BC_W-1:0]   r_bit_count,  w_bit_count_nxt;
    logic [WA_W-1:0]   r_words,      w_words_nxt;
    logic [7:0]        r_crc_load,   w_crc_load_nxt;
    logic [7:0]        r_crc_rb,     w_crc_rb_nxt;
    logic              r_err,        w_err_nxt;

    logic [BC_W-1:0]   w_remaining;
    logic [BC_W-1:0]   w_bc_inc;
    logic [RC_W-1:0]   w_load_cnt;
    logic              w_ready;
    logic              w_shift_en;
    logic              w_head;

    // Last word is clipped to the bits the chain still needs, dropping its upper bits.
    assign w_remaining = LAST_BIT - r_bit_count;
    assign w_bc_inc    = r_bit_count + BC_ONE;
    assign w_load_cnt  = (int'(w_remaining) > WORD_W) ? WORD_CNT : RC_W'(w_remaining);

    // Next-state and Moore/Mealy output decode for the load/verify sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_buf_nxt       = r_buf;
        w_cnt_nxt       = r_cnt;
        w_bit_count_nxt = r_bit_count;
        w_words_nxt     = r_words;
        w_crc_load_nxt  = r_crc_load;
        w_crc_rb_nxt    = r_crc_rb;
        w_err_nxt       = r_err;
        w_ready         = 1'b0;
        w_shift_en      = 1'b0;
        w_head          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt     = S_LOAD;
                    w_buf_nxt       = {WORD_W{1'b0}};
                    w_cnt_nxt       = RC_ZERO;
                    w_bit_count_nxt = BC_ZERO;
                    w_words_nxt     = WA_ZERO;
                    w_crc_load_nxt  = 8'h00;
                    w_crc_rb_nxt    = 8'h00;
                    w_err_nxt       = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_LOAD: begin
                // Abort gates ready so a word offered alongside it is never taken.
                w_ready = (r_cnt == RC_ZERO) && (r_words < WORDS_MAX) && !abort;
                if (r_cnt != RC_ZERO) begin
                    w_shift_en      = 1'b1;
                    w_head          = r_buf[0];
                    w_buf_nxt       = {1'b0, r_buf[WORD_W-1:1]};
                    w_cnt_nxt       = r_cnt - RC_ONE;
                    w_bit_count_nxt = w_bc_inc;
                    w_crc_load_nxt  = crc8_step(r_crc_load, r_buf[0]);
                    if (w_bc_inc == LAST_BIT) begin
                        w_state_nxt     = S_VERIFY;
                        w_bit_count_nxt = BC_ZERO;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end else if (cfg_valid && w_ready) begin
                    w_buf_nxt   = cfg_data;
                    w_cnt_nxt   = w_load_cnt;
                    w_words_nxt = r_words + WA_ONE;
                end else begin
                    w_state_nxt = S_LOAD;
                end
                if (abort) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_err_nxt = r_err;
                end
            end

            S_VERIFY: begin
                w_shift_en      = 1'b1;
                w_head          = ccff_tail;
                w_crc_rb_nxt    = crc8_step(r_crc_rb, ccff_tail);
                w_bit_count_nxt = w_bc_inc;
                if (w_bc_inc == LAST_BIT) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_VERIFY;
                end
                if (abort) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_err_nxt = r_err;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                if (r_crc_load != r_crc_rb) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_err_nxt = r_err;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state     <= S_IDLE;
            r_buf       <= {WORD_W{1'b0}};
            r_cnt       <= RC_ZERO;
            r_bit_count <= BC_ZERO;
            r_words     <= WA_ZERO;
            r_crc_load  <= 8'h00;
            r_crc_rb    <= 8'h00;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf       <= w_buf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_count <= w_bit_count_nxt;
            r_words     <= w_words_nxt;
            r_crc_load  <= w_crc_load_nxt;
            r_crc_rb    <= w_crc_rb_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign cfg_ready = w_ready;
    assign shift_en  = w_shift_en;
    assign ccff_head = w_head;
    assign bit_count = r_bit_count;
    assign busy      = (r_state == S_LOAD) || (r_state == S_VERIFY);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: a 24-bit and a 20-bit chain model driven by two loader instances.
module tb_ccff_chain_loader;

    logic       prog_clk  = 1'b0;
    logic       pReset    = 1'b1;
    logic [7:0] cfg_data  = 8'h00;
    logic       cfg_valid = 1'b0;

    logic       a_start = 1'b0;
    logic       a_abort, a_ready, a_head, a_tail, a_shift, a_busy, a_done, a_err;
    logic [4:0] a_bc;
    logic       b_start = 1'b0;
    logic       b_abort, b_ready, b_head, b_tail, b_shift, b_busy, b_done, b_err;
    logic [4:0] b_bc;

    logic [23:0] a_chain = 24'h0;
    logic [19:0] b_chain = 20'h0;
    int a_shift_cnt = 0, a_done_cnt = 0, b_shift_cnt = 0, b_done_cnt = 0;
    int b_late_ready = 0, b_sent = 0, a_base = 0;
    bit a_inj_en = 1'b0, a_abort_arm = 1'b0;
    int n_checks = 0, n_errs = 0;
    logic [7:0] words [3] = '{8'hA5, 8'h3C, 8'h0F};

    always #5 prog_clk = ~prog_clk;

    // Tail fault on the 10th VERIFY cycle; abort during the 12th LOAD shift.
    assign a_tail  = a_chain[0] ^ (a_inj_en && ((a_shift_cnt - a_base) == 33));
    assign a_abort = a_abort_arm && ((a_shift_cnt - a_base) == 11);
    assign b_tail  = b_chain[0];
    assign b_abort = 1'b0;

    ccff_chain_loader #(.CHAIN_LEN(24), .WORD_W(8)) dut_a (
        .prog_clk(prog_clk), .pReset(pReset), .start(a_start), .abort(a_abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(a_ready),
        .ccff_head(a_head), .ccff_tail(a_tail), .shift_en(a_shift), .bit_count(a_bc),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(b_start), .abort(b_abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(b_ready),
        .ccff_head(b_head), .ccff_tail(b_tail), .shift_en(b_shift), .bit_count(b_bc),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    // Gated-clock chain models plus event counters.
    always @(posedge prog_clk) begin
        if (a_shift) begin
            a_chain     <= {a_head, a_chain[23:1]};
            a_shift_cnt <= a_shift_cnt + 1;
        end
        if (b_shift) begin
            b_chain     <= {b_head, b_chain[19:1]};
            b_shift_cnt <= b_shift_cnt + 1;
        end
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
        if (b_sent == 3 && b_ready) b_late_ready <= b_late_ready + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] w);
        int n;
        n = 0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        while (((sel ? b_ready : a_ready) !== 1'b1) && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        if (n >= 100) chk("send_ready", 32'(sel ? b_ready : a_ready), 32'd1);
        @(negedge prog_clk);
        cfg_valid = 1'b0;
        if (sel) b_sent++;
    endtask

    task automatic wait_done_a();
        int n;
        n = 0;
        while (a_done !== 1'b1 && n < 300) begin
            if ((a_shift_cnt - a_base) == 24) chk("verify_bc_clr", 32'(a_bc), 32'd0);
            @(negedge prog_clk);
            n++;
        end
        chk("done_pulse", 32'(a_done), 32'd1);
    endtask

    task automatic pulse_start_a();
        @(negedge prog_clk);
        a_start = 1'b1;
        @(negedge prog_clk);
        a_start = 1'b0;
        chk("start_busy", 32'(a_busy), 32'd1);
        chk("start_err_clr", 32'(a_err), 32'd0);
        chk("start_bc", 32'(a_bc), 32'd0);
    endtask

    task automatic load_verify(input bit gap, input bit inj, input bit exp_err);
        int dbase, n;
        a_base   = a_shift_cnt;
        dbase    = a_done_cnt;
        a_inj_en = inj;
        pulse_start_a();
        send(1'b0, words[0]);
        for (int i = 1; i < 3; i++) begin
            if (gap) begin
                n = 0;
                while (a_ready !== 1'b1 && n < 50) begin
                    @(negedge prog_clk);
                    n++;
                end
                for (int k = 0; k < 5; k++) begin
                    chk("gap_shift_en", 32'(a_shift), 32'd0);
                    chk("gap_head", 32'(a_head), 32'd0);
                    chk("gap_bc", 32'(a_bc), 32'(8 * i));
                    a_start = (k == 2);
                    @(negedge prog_clk);
                end
                a_start = 1'b0;
            end
            send(1'b0, words[i]);
        end
        wait_done_a();
        chk("done_busy", 32'(a_busy), 32'd0);
        @(negedge prog_clk);
        chk("done_once", 32'(a_done), 32'd0);
        chk("err", 32'(a_err), 32'(exp_err));
        chk("shift_total", 32'(a_shift_cnt - a_base), 32'd48);
        chk("done_count", 32'(a_done_cnt - dbase), 32'd1);
        if (!inj) chk("chain", 32'(a_chain), 32'h000F3CA5);
        a_inj_en = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge prog_clk);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_shift", 32'(a_shift), 32'd0);
        chk("rst_head", 32'(a_head), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_bc", 32'(a_bc), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        pReset = 1'b0;

        load_verify(1'b0, 1'b0, 1'b0);
        load_verify(1'b1, 1'b0, 1'b0);
        load_verify(1'b0, 1'b1, 1'b1);

        // Abort mid-LOAD, then a fresh start must clear err and complete.
        a_base      = a_shift_cnt;
        a_abort_arm = 1'b1;
        pulse_start_a();
        send(1'b0, words[0]);
        send(1'b0, words[1]);
        wait_done_a();
        chk("abort_shift_en", 32'(a_shift), 32'd0);
        chk("abort_err", 32'(a_err), 32'd1);
        chk("abort_shifts", 32'(a_shift_cnt - a_base), 32'd12);
        a_abort_arm = 1'b0;
        @(negedge prog_clk);
        chk("abort_done_once", 32'(a_done), 32'd0);
        load_verify(1'b0, 1'b0, 1'b0);

        // Reset mid-VERIFY.
        a_base = a_shift_cnt;
        pulse_start_a();
        for (int i = 0; i < 3; i++) send(1'b0, words[i]);
        n = 0;
        while ((a_shift_cnt - a_base) < 30 && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        chk("pre_rst_busy", 32'(a_busy), 32'd1);
        pReset = 1'b1;
        #1;
        chk("mid_rst_shift", 32'(a_shift), 32'd0);
        chk("mid_rst_head", 32'(a_head), 32'd0);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_ready", 32'(a_ready), 32'd0);
        chk("mid_rst_done", 32'(a_done), 32'd0);
        chk("mid_rst_err", 32'(a_err), 32'd0);
        chk("mid_rst_bc", 32'(a_bc), 32'd0);
        @(negedge prog_clk);
        pReset = 1'b0;
        load_verify(1'b0, 1'b0, 1'b0);

        // Partial final word on the 20-bit chain.
        begin
            int bbase, bdbase;
            bbase  = b_shift_cnt;
            bdbase = b_done_cnt;
            @(negedge prog_clk);
            b_start = 1'b1;
            @(negedge prog_clk);
            b_start = 1'b0;
            send(1'b1, 8'hFF);
            send(1'b1, 8'h00);
            send(1'b1, 8'hFA);
            n = 0;
            while (b_done !== 1'b1 && n < 300) begin
                @(negedge prog_clk);
                n++;
            end
            chk("b_done_pulse", 32'(b_done), 32'd1);
            @(negedge prog_clk);
            chk("b_err", 32'(b_err), 32'd0);
            chk("b_shift_total", 32'(b_shift_cnt - bbase), 32'd40);
            chk("b_late_ready", 32'(b_late_ready), 32'd0);
            chk("b_chain", 32'(b_chain), 32'h000A00FF);
            chk("b_done_count", 32'(b_done_cnt - bdbase), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
